ddr3_cmd_model: RTL and testbench
=================================

Name: ddr3_cmd_model

Overview:
- Parametrised, single-clock, command-level DDR3 device model. It replaces the fixed x8 vendor-model wrapper in block-level benches and in lightweight system simulation.
- Decodes DDR3 commands, tracks per-bank open rows and activate timing, stores data in an internal array, and returns read bursts after CAS latency.
- Data is abstracted to one beat per rising edge of ck (SDR beat model). DQ and DQS are split into in/out/enable signals, with no inout ports.

Parameters:
- DQ_WIDTH, 8, data bits per beat; must be a multiple of 8.
- ADDR_BITS, 14, row/command address width.
- BA_BITS, 3, bank address width; bank count = 2^BA_BITS.
- COL_BITS, 10, column bits taken from addr[COL_BITS-1:0].
- MEM_AW, 14, internal storage depth = 2^MEM_AW beats; storage index = {ba, row, col} truncated to the low MEM_AW bits.
- CL, 6, read latency in cycles from RD to first beat; minimum 2.
- CWL, 5, write latency in cycles from WR to first sampled beat; minimum 1.
- BL, 8, burst length in beats; power of two, up to 8.
- TRCD, 6, minimum cycles from ACT to RD/WR on the same bank.
- TRP, 6, minimum cycles from PRE to ACT on the same bank.

Ports:
- ck  in  1  clock; all logic on the rising edge
- rst_n  in  1  asynchronous active-low reset
- cke  in  1  clock enable; commands are decoded only when high
- cs_n, ras_n, cas_n, we_n  in  1 each  command pins
- ba  in  BA_BITS  bank address
- addr  in  ADDR_BITS  row/column address; addr[10] = auto-precharge / all-banks
- dq_in  in  DQ_WIDTH  write data beat
- dm  in  DQ_WIDTH/8  write byte mask; 1 = masked
- dq_out  out  DQ_WIDTH  read data beat
- dq_oe  out  1  high while dq_out carries a valid read beat
- dqs_oe  out  1  read preamble plus burst strobe window
- err_proto  out  1  one-cycle pulse on an illegal command
- err_timing  out  1  one-cycle pulse on a TRCD/TRP violation
- err_bus  out  1  one-cycle pulse when read and write data windows collide

Behaviour:
- Reset (async assert, sync release): all banks IDLE, all timers 0, burst pipelines flushed, and all outputs 0. Storage contents are retained across reset.
- Decode rule: a command is decoded only when cke=1 and cs_n=0. The command is {ras_n,cas_n,we_n}:
  - 111 = NOP
  - 011 = ACT
  - 101 = RD
  - 100 = WR
  - 010 = PRE
  - 001 = REF
  - 000 = MRS
  - 110 = ZQ, treated as NOP
- cke=0: no new commands are decoded. Bursts already in flight complete.
- Per-bank FSM (IDLE, ACTIVE):
  - ACT to an IDLE bank with its TRP timer at 0: bank goes to ACTIVE, latches row = addr, and loads the TRCD timer.
  - ACT to an ACTIVE bank: err_proto, command ignored.
  - ACT to an IDLE bank with TRP timer nonzero: err_timing, command ignored.
- PRE: the bank goes to IDLE and its TRP timer is loaded.
  - With addr[10]=1, every ACTIVE bank is precharged.
  - PRE to an IDLE bank is a legal no-op.
- RD/WR legality and addressing:
  - RD/WR to an IDLE bank: err_proto, command dropped.
  - RD/WR while the bank's TRCD timer is nonzero: err_timing, command dropped.
  - Start column = addr[COL_BITS-1:0]. Beats wrap within the BL-aligned block: beat k uses col = {col[hi:log2BL], col[log2BL-1:0]+k mod BL}.
- RD timing:
  - Beat 0 appears on dq_out with dq_oe=1 exactly CL cycles after the RD edge. Beats 1..BL-1 follow on consecutive cycles.
  - dqs_oe rises one cycle before beat 0 (preamble) and falls with the last beat.
- WR timing: beat k is sampled from dq_in at CWL+k cycles after the WR edge. Bytes with dm=1 are left unchanged.
- Auto-precharge: when addr[10]=1 on a RD/WR, the bank goes to IDLE after the last beat and its TRP timer is loaded.
- Back-to-back bursts:
  - Commands of the same direction may be spaced BL cycles or more apart; the pipelines hold up to ceil((CL+BL)/BL) bursts in flight.
  - A same-direction command spaced fewer than BL cycles from the previous one raises err_timing and is dropped.
- Data-window collision: if a read beat and a write beat occupy the same cycle, err_bus pulses, the write beat is dropped, and the read beat is driven.
- Read-after-write ordering: a read of a location written in the same cycle returns the old data.
- REF:
  - Legal only when all banks are IDLE. Otherwise err_proto.
  - Has no data effect.
- Simultaneous errors: more than one error flag may pulse in the same cycle.
- Timers: saturating down-counters, one TRCD and one TRP per bank.

Optional Feature:
- Macro DDR3_CMD_MRS_EN.
- Defined: MRS with ba=0 loads the runtime read latency rcl = addr[6:4]+4, clamped to the range [2, CL+4]. Read pipelines are sized for CL+4.
  - An MRS while any bank is ACTIVE or any burst is in flight raises err_proto and is ignored.
- Undefined: MRS is accepted as a no-op, and read latency is fixed at CL.

Test Plan:
- ACT b0 row 0x12, wait 6, WR col 0x0 with beats 0x10..0x17 and dm=0, PRE, ACT, RD col 0x0 -> dq_oe high exactly 6 cycles after RD; beats 0x10..0x17 in order; dqs_oe rises 1 cycle earlier.
- RD col 0x5 on a written block -> beat order is the data of columns 5,6,7,0,1,2,3,4.
- RD with no prior ACT -> err_proto pulses for 1 cycle and dq_oe stays 0. RD 3 cycles after ACT -> err_timing pulses.
- WR with dm=1 on beats 2 and 5 over existing 0xAA data -> readback shows 0xAA at beats 2 and 5.
- RD at cycle t, WR at t+1 with CWL=5 -> err_bus pulses at the colliding cycle; the read beats are intact and the write beat is not stored.
- Assert rst_n low mid-read-burst -> dq_oe and dqs_oe drop to 0 immediately and all banks are IDLE. After release, an RD without ACT raises err_proto.

Source files
------------

// File: rtl/ddr3_cmd_model.sv
// ddr3_cmd_model: command-level DDR3 device model with per-bank timing checks and SDR beat data.
// Define DDR3_CMD_MRS_EN to let MRS (ba=0) program the read latency at runtime.
module ddr3_cmd_model #(
  parameter int DQ_WIDTH  = 8,
  parameter int ADDR_BITS = 14,
  parameter int BA_BITS   = 3,
  parameter int COL_BITS  = 10,
  parameter int MEM_AW    = 14,
  parameter int CL        = 6,
  parameter int CWL       = 5,
  parameter int BL        = 8,
  parameter int TRCD      = 6,
  parameter int TRP       = 6
) (
  input  logic                  ck,
  input  logic                  rst_n,
  input  logic                  cke,
  input  logic                  cs_n,
  input  logic                  ras_n,
  input  logic                  cas_n,
  input  logic                  we_n,
  input  logic [BA_BITS-1:0]    ba,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [DQ_WIDTH-1:0]   dq_in,
  input  logic [DQ_WIDTH/8-1:0] dm,
  output logic [DQ_WIDTH-1:0]   dq_out,
  output logic                  dq_oe,
  output logic                  dqs_oe,
  output logic                  err_proto,
  output logic                  err_timing,
  output logic                  err_bus
);
  localparam int NB = 2**BA_BITS;
  localparam int TW = $clog2(TRCD + TRP + 2);
`ifdef DDR3_CMD_MRS_EN
  localparam int RLM = CL + 4;
`else
  localparam int RLM = CL;
`endif
  localparam int RD_D = RLM + BL - 1;
  localparam int WR_D = CWL + BL - 1;
  localparam int GW = $clog2(BL + 1);
  localparam int RW = $clog2(RLM + 1);
  localparam logic [TW-1:0] TRCD_LD = TW'(TRCD > 0 ? TRCD - 1 : 0);
  localparam logic [TW-1:0] TRP_LD = TW'(TRP > 0 ? TRP - 1 : 0);
  typedef enum logic {IDLE, ACTIVE} bank_st_t;
  bank_st_t st [NB];
  bank_st_t st_nx [NB];
  logic [TW-1:0] trcd [NB];
  logic [TW-1:0] trcd_nx [NB];
  logic [TW-1:0] trp [NB];
  logic [TW-1:0] trp_nx [NB];
  logic [ADDR_BITS-1:0] row [NB];
  logic [ADDR_BITS-1:0] row_nx [NB];
  logic [GW-1:0] rd_gap, rd_gap_nx, wr_gap, wr_gap_nx;
  logic [RD_D-1:0] rd_v, rd_v_nx, rd_last, rd_last_nx, rd_ap, rd_ap_nx;
  logic [MEM_AW-1:0] rd_idx [RD_D];
  logic [MEM_AW-1:0] rd_idx_nx [RD_D];
  logic [BA_BITS-1:0] rd_bank [RD_D];
  logic [BA_BITS-1:0] rd_bank_nx [RD_D];
  logic [WR_D-1:0] wr_v, wr_v_nx, wr_last, wr_last_nx, wr_ap, wr_ap_nx;
  logic [MEM_AW-1:0] wr_idx [WR_D];
  logic [MEM_AW-1:0] wr_idx_nx [WR_D];
  logic [BA_BITS-1:0] wr_bank [WR_D];
  logic [BA_BITS-1:0] wr_bank_nx [WR_D];
  logic [DQ_WIDTH-1:0] mem [2**MEM_AW];
  logic [RW-1:0] rcl;
  logic dec, is_act, is_rd, is_wr, is_pre, is_ref;
  logic e_proto, e_timing, acc_rd, acc_wr, any_act;
  int rl;
  assign dec = cke & ~cs_n;
  assign is_act = dec && {ras_n, cas_n, we_n} == 3'b011;
  assign is_rd = dec && {ras_n, cas_n, we_n} == 3'b101;
  assign is_wr = dec && {ras_n, cas_n, we_n} == 3'b100;
  assign is_pre = dec && {ras_n, cas_n, we_n} == 3'b010;
  assign is_ref = dec && {ras_n, cas_n, we_n} == 3'b001;
  // Beat k of a burst wraps its column inside the BL-aligned block.
  function automatic logic [MEM_AW-1:0] beat_idx(input logic [BA_BITS-1:0] b,
      input logic [ADDR_BITS-1:0] r, input logic [COL_BITS-1:0] c, input int k);
    logic [COL_BITS-1:0] m;
    logic [COL_BITS-1:0] cw;
    m = COL_BITS'(BL - 1);
    cw = (c & ~m) | ((c + COL_BITS'(k)) & m);
    return MEM_AW'({b, r, cw});
  endfunction
`ifdef DDR3_CMD_MRS_EN
  logic is_mrs;
  logic [RW-1:0] rcl_nx;
  int mv;
  assign is_mrs = dec && {ras_n, cas_n, we_n} == 3'b000;
  always_ff @(posedge ck or negedge rst_n)
    if (!rst_n) rcl <= RW'(CL);
    else rcl <= rcl_nx;
`else
  assign rcl = RW'(CL);
`endif
  always_comb begin
    for (int b = 0; b < NB; b++) begin
      st_nx[b] = st[b];
      trcd_nx[b] = trcd[b] != '0 ? trcd[b] - 1'b1 : '0;
      trp_nx[b] = trp[b] != '0 ? trp[b] - 1'b1 : '0;
      row_nx[b] = row[b];
    end
    rd_v_nx = rd_v >> 1;
    rd_last_nx = rd_last >> 1;
    rd_ap_nx = rd_ap >> 1;
    for (int j = 0; j < RD_D; j++) begin
      rd_idx_nx[j] = j < RD_D - 1 ? rd_idx[j + 1] : '0;
      rd_bank_nx[j] = j < RD_D - 1 ? rd_bank[j + 1] : '0;
    end
    wr_v_nx = wr_v >> 1;
    wr_last_nx = wr_last >> 1;
    wr_ap_nx = wr_ap >> 1;
    for (int j = 0; j < WR_D; j++) begin
      wr_idx_nx[j] = j < WR_D - 1 ? wr_idx[j + 1] : '0;
      wr_bank_nx[j] = j < WR_D - 1 ? wr_bank[j + 1] : '0;
    end
    rd_gap_nx = rd_gap != '0 ? rd_gap - 1'b1 : '0;
    wr_gap_nx = wr_gap != '0 ? wr_gap - 1'b1 : '0;
    rl = int'(rcl);
    e_proto = 1'b0;
    e_timing = 1'b0;
    acc_rd = 1'b0;
    acc_wr = 1'b0;
    any_act = 1'b0;
    for (int b = 0; b < NB; b++) any_act = any_act | (st[b] == ACTIVE);
    // Auto-precharge closes the bank on the edge of its last beat.
    if (rd_v[0] && rd_last[0] && rd_ap[0]) begin
      st_nx[rd_bank[0]] = IDLE;
      trp_nx[rd_bank[0]] = TRP_LD;
    end
    if (wr_v[0] && wr_last[0] && wr_ap[0]) begin
      st_nx[wr_bank[0]] = IDLE;
      trp_nx[wr_bank[0]] = TRP_LD;
    end
    if (is_act) begin
      if (st[ba] == ACTIVE) e_proto = 1'b1;
      else if (trp[ba] != '0) e_timing = 1'b1;
      else begin
        st_nx[ba] = ACTIVE;
        row_nx[ba] = addr;
        trcd_nx[ba] = TRCD_LD;
      end
    end
    if (is_pre)
      for (int b = 0; b < NB; b++)
        if (st[b] == ACTIVE && (addr[10] || ba == BA_BITS'(b))) begin
          st_nx[b] = IDLE;
          trp_nx[b] = TRP_LD;
        end
    if (is_rd || is_wr) begin
      if (st[ba] != ACTIVE) e_proto = 1'b1;
      else if (trcd[ba] != '0 || (is_rd ? rd_gap != '0 : wr_gap != '0)) e_timing = 1'b1;
      else begin
        acc_rd = is_rd;
        acc_wr = is_wr;
      end
    end
    if (is_ref && any_act) e_proto = 1'b1;
`ifdef DDR3_CMD_MRS_EN
    rcl_nx = rcl;
    mv = int'(addr[6:4]) + 4;
    if (is_mrs) begin
      if (any_act || |rd_v || |wr_v) e_proto = 1'b1;
      else if (ba == '0) rcl_nx = RW'(mv < 2 ? 2 : mv > CL + 4 ? CL + 4 : mv);
    end
`endif
    if (acc_rd) begin
      rd_gap_nx = GW'(BL - 1);
      for (int j = 0; j < RD_D; j++)
        if (j >= rl - 1 && j < rl - 1 + BL) begin
          rd_v_nx[j] = 1'b1;
          rd_last_nx[j] = j == rl + BL - 2;
          rd_ap_nx[j] = addr[10];
          rd_idx_nx[j] = beat_idx(ba, row[ba], addr[COL_BITS-1:0], j - rl + 1);
          rd_bank_nx[j] = ba;
        end
    end
    if (acc_wr) begin
      wr_gap_nx = GW'(BL - 1);
      for (int j = 0; j < WR_D; j++)
        if (j >= CWL - 1) begin
          wr_v_nx[j] = 1'b1;
          wr_last_nx[j] = j == WR_D - 1;
          wr_ap_nx[j] = addr[10];
          wr_idx_nx[j] = beat_idx(ba, row[ba], addr[COL_BITS-1:0], j - CWL + 1);
          wr_bank_nx[j] = ba;
        end
    end
  end
  always_ff @(posedge ck or negedge rst_n)
    if (!rst_n) begin
      for (int b = 0; b < NB; b++) begin
        st[b] <= IDLE;
        trcd[b] <= '0;
        trp[b] <= '0;
        row[b] <= '0;
      end
      for (int j = 0; j < RD_D; j++) begin
        rd_idx[j] <= '0;
        rd_bank[j] <= '0;
      end
      for (int j = 0; j < WR_D; j++) begin
        wr_idx[j] <= '0;
        wr_bank[j] <= '0;
      end
      {rd_v, rd_last, rd_ap} <= '0;
      {wr_v, wr_last, wr_ap} <= '0;
      rd_gap <= '0;
      wr_gap <= '0;
      dq_out <= '0;
      dq_oe <= 1'b0;
      dqs_oe <= 1'b0;
      err_proto <= 1'b0;
      err_timing <= 1'b0;
      err_bus <= 1'b0;
    end else begin
      st <= st_nx;
      trcd <= trcd_nx;
      trp <= trp_nx;
      row <= row_nx;
      rd_v <= rd_v_nx;
      rd_last <= rd_last_nx;
      rd_ap <= rd_ap_nx;
      rd_idx <= rd_idx_nx;
      rd_bank <= rd_bank_nx;
      wr_v <= wr_v_nx;
      wr_last <= wr_last_nx;
      wr_ap <= wr_ap_nx;
      wr_idx <= wr_idx_nx;
      wr_bank <= wr_bank_nx;
      rd_gap <= rd_gap_nx;
      wr_gap <= wr_gap_nx;
      dq_oe <= rd_v[0];
      dq_out <= rd_v[0] ? mem[rd_idx[0]] : '0;
      dqs_oe <= rd_v[0] | rd_v[1];
      err_proto <= e_proto;
      err_timing <= e_timing;
      err_bus <= rd_v[0] & wr_v[0];
    end
  // Storage survives reset; a write beat colliding with a read beat is dropped.
  always_ff @(posedge ck)
    if (wr_v[0] && !rd_v[0])
      for (int i = 0; i < DQ_WIDTH / 8; i++)
        if (!dm[i]) mem[wr_idx[0]][8*i +: 8] <= dq_in[8*i +: 8];
endmodule

// File: tb/tb_ddr3_cmd_model.sv
// tb_ddr3_cmd_model: directed checks of decode, timing errors, burst data, masking, collisions and reset.
module tb_ddr3_cmd_model;
  localparam int CL = 6;
  localparam int CWL = 5;
  localparam int BL = 8;
  localparam logic [2:0] ACT = 3'b011, RD = 3'b101, WR = 3'b100, PRE = 3'b010, REF = 3'b001;
  logic ck = 1'b0, rst_n = 1'b0, cke = 1'b1, cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
  logic [2:0] ba = '0;
  logic [13:0] addr = '0;
  logic [7:0] dq_in = '0;
  logic [0:0] dm = '0;
  logic [7:0] dq_out;
  logic dq_oe, dqs_oe, err_proto, err_timing, err_bus;
  int n_cmp = 0, n_bad = 0;
  always #5 ck = ~ck;
  ddr3_cmd_model #(.CL(CL), .CWL(CWL), .BL(BL)) dut (
    .ck(ck), .rst_n(rst_n), .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
    .ba(ba), .addr(addr), .dq_in(dq_in), .dm(dm), .dq_out(dq_out), .dq_oe(dq_oe),
    .dqs_oe(dqs_oe), .err_proto(err_proto), .err_timing(err_timing), .err_bus(err_bus)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // Called at a falling edge; returns at the falling edge after the command edge.
  task automatic drive(input logic [2:0] c, input logic [2:0] b, input logic [13:0] a);
    cs_n = 1'b0;
    {ras_n, cas_n, we_n} = c;
    ba = b;
    addr = a;
    @(negedge ck);
    cs_n = 1'b1;
    {ras_n, cas_n, we_n} = 3'b111;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge ck);
  endtask
  task automatic wr_burst(input logic [2:0] b, input logic [13:0] a, input logic [63:0] d, input logic [7:0] m);
    drive(WR, b, a);
    check("wr_cmd_err", {30'd0, err_proto, err_timing}, 32'd0);
    idle(CWL - 1);
    for (int k = 0; k < BL; k++) begin
      dq_in = d[8*k +: 8];
      dm = m[k];
      @(negedge ck);
    end
    dq_in = '0;
    dm = '0;
  endtask
  task automatic rd_check(input string tag, input logic [2:0] b, input logic [13:0] a, input logic [63:0] d);
    drive(RD, b, a);
    check({tag, "_cmd_err"}, {30'd0, err_proto, err_timing}, 32'd0);
    for (int j = 0; j <= CL + BL; j++) begin
      if (j == CL - 2) check({tag, "_idle"}, {30'd0, dqs_oe, dq_oe}, 32'd0);
      if (j == CL - 1) check({tag, "_preamble"}, {30'd0, dqs_oe, dq_oe}, 32'd2);
      if (j >= CL && j < CL + BL) check({tag, "_beat"}, {22'd0, dqs_oe, dq_oe, dq_out}, {22'd0, 2'b11, d[8*(j-CL) +: 8]});
      if (j == CL + BL) check({tag, "_end"}, {30'd0, dqs_oe, dq_oe}, 32'd0);
      @(negedge ck);
    end
  endtask
  initial begin
    idle(2);
    check("reset_outs", {19'd0, dq_out, dq_oe, dqs_oe, err_proto, err_timing, err_bus}, 32'd0);
    rst_n = 1'b1;
    idle(1);
    drive(ACT, 3'd0, 14'h012);
    check("act_err", {30'd0, err_proto, err_timing}, 32'd0);
    idle(5);
    wr_burst(3'd0, 14'h000, 64'h1716151413121110, 8'h00);
    drive(PRE, 3'd0, 14'h000);
    idle(5);
    drive(ACT, 3'd0, 14'h012);
    check("react_err", {30'd0, err_proto, err_timing}, 32'd0);
    idle(5);
    rd_check("rd0", 3'd0, 14'h000, 64'h1716151413121110);
    rd_check("rd5", 3'd0, 14'h005, 64'h1413121110171615);
    drive(PRE, 3'd0, 14'h400);
    drive(RD, 3'd1, 14'h000);
    check("rd_idle_proto", {30'd0, err_proto, err_timing}, 32'd2);
    idle(1);
    check("proto_pulse", {31'd0, err_proto}, 32'd0);
    idle(CL);
    check("rd_idle_no_oe", {30'd0, dqs_oe, dq_oe}, 32'd0);
    drive(ACT, 3'd2, 14'h001);
    idle(2);
    drive(RD, 3'd2, 14'h008);
    check("rd_trcd_timing", {30'd0, err_proto, err_timing}, 32'd1);
    idle(2);
    wr_burst(3'd2, 14'h008, 64'hAAAAAAAAAAAAAAAA, 8'h00);
    wr_burst(3'd2, 14'h008, 64'h5756555453525150, 8'h24);
    wr_burst(3'd2, 14'h010, 64'h3333333333333333, 8'h00);
    rd_check("rd_dm", 3'd2, 14'h008, 64'h5756AA5453AA5150);
    drive(RD, 3'd2, 14'h008);
    drive(WR, 3'd2, 14'h010);
    check("coll_cmd_err", {30'd0, err_proto, err_timing}, 32'd0);
    idle(CWL - 1);
    for (int k = 0; k < BL; k++) begin
      logic [63:0] exp_d;
      exp_d = 64'h5756AA5453AA5150;
      dq_in = 8'(8'hF0 + k);
      @(negedge ck);
      check("coll_beat", {21'd0, err_bus, dq_oe, dq_out}, {21'd0, 2'b11, exp_d[8*k +: 8]});
    end
    dq_in = '0;
    @(negedge ck);
    check("coll_end", {30'd0, err_bus, dq_oe}, 32'd0);
    rd_check("rd_nowrite", 3'd2, 14'h010, 64'h3333333333333333);
    drive(RD, 3'd2, 14'h008);
    idle(CL + 1);
    check("mid_burst_oe", {30'd0, dqs_oe, dq_oe}, 32'd3);
    #2 rst_n = 1'b0;
    #1 check("reset_async", {30'd0, dqs_oe, dq_oe}, 32'd0);
    @(negedge ck);
    rst_n = 1'b1;
    idle(1);
    drive(RD, 3'd2, 14'h008);
    check("rd_after_reset", {30'd0, err_proto, err_timing}, 32'd2);
    drive(ACT, 3'd2, 14'h001);
    check("act_after_reset", {30'd0, err_proto, err_timing}, 32'd0);
    drive(REF, 3'd0, 14'h000);
    check("ref_active", {30'd0, err_proto, err_timing}, 32'd2);
    idle(4);
    drive(RD, 3'd2, 14'h008);
    check("rd_ok", {30'd0, err_proto, err_timing}, 32'd0);
    drive(RD, 3'd2, 14'h008);
    check("rd_spacing", {30'd0, err_proto, err_timing}, 32'd1);
    idle(CL + BL + 2);
    check("final_idle", {29'd0, dqs_oe, dq_oe, err_bus}, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
